fsgnj_arb: RTL and testbench

- Shares one sign-injection datapath between two issue requesters (integer-pipe FP move path and FP-pipe issue slot).
- Round-robin arbitration with a valid/ready handshake per requester.
- Computes FSGNJ/FSGNJN/FSGNJX on the granted operands and holds the result in a one-entry output register until the writeback consumer accepts it.
- Sits between FP issue and FP writeback in the core.

---
 rtl/fsgnj_pkg.sv | 34 +++
 rtl/fsgnj_core.sv | 44 ++++
 rtl/fsgnj_arb.sv | 106 ++++++++++
 tb/tb_fsgnj_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsgnj_pkg.sv
// Shared definitions for the sign-injection arbiter: op encodings, format sizes,
// NaN-box constants and the sign rule.
package fsgnj_pkg;

  localparam logic [1:0] FSGNJ_OP_J  = 2'b00;
  localparam logic [1:0] FSGNJ_OP_JN = 2'b01;
  localparam logic [1:0] FSGNJ_OP_JX = 2'b10;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam logic [31:0] NANBOX_MASK = 32'hFFFF_FFFF;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int mantissa_size(input int bus_width);
    return (bus_width == 64) ? 52 : 23;
  endfunction

  function automatic int exponent_size(input int bus_width);
    return (bus_width == 64) ? 11 : 8;
  endfunction

  // Reserved op 11 falls through to plain J.
  function automatic logic inject_sign(input logic s1, input logic s2, input logic [1:0] op);
    case (op)
      FSGNJ_OP_JN: return ~s2;
      FSGNJ_OP_JX: return s1 ^ s2;
      default:     return s2;
    endcase
  endfunction

endpackage

// File: rtl/fsgnj_core.sv
// Combinational sign injection: {sign(op, in1, in2), magnitude of in1}.
// NaN-boxed single handling for 64-bit builds is enabled by FSGNJ_NANBOX_EN.
module fsgnj_core
  import fsgnj_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] i_in1,
  input  logic [BUS_WIDTH-1:0] i_in2,
  input  logic [1:0]           i_op,
  input  logic                 i_fmt,
  output logic [BUS_WIDTH-1:0] o_result
);

  localparam int MAG_W = mantissa_size(BUS_WIDTH) + exponent_size(BUS_WIDTH);

  logic [BUS_WIDTH-1:0] w_full;

  // Magnitude bits are copied verbatim, so NaN payloads pass through untouched.
  assign w_full = {inject_sign(i_in1[BUS_WIDTH-1], i_in2[BUS_WIDTH-1], i_op), i_in1[MAG_W-1:0]};

`ifdef FSGNJ_NANBOX_EN
  generate
    if (BUS_WIDTH == 64) begin : g_nanbox
      logic [31:0] w_a;
      logic [31:0] w_b;
      // An improperly boxed single reads as the canonical quiet NaN.
      assign w_a = (i_in1[63:32] == NANBOX_MASK) ? i_in1[31:0] : CANON_NAN_S;
      assign w_b = (i_in2[63:32] == NANBOX_MASK) ? i_in2[31:0] : CANON_NAN_S;
      assign o_result = i_fmt ? {NANBOX_MASK, inject_sign(w_a[31], w_b[31], i_op), w_a[30:0]}
                              : w_full;
    end else begin : g_nobox
      logic w_unused_fmt;
      assign w_unused_fmt = i_fmt;
      assign o_result = w_full;
    end
  endgenerate
`else
  logic w_unused_fmt;
  assign w_unused_fmt = i_fmt;
  assign o_result = w_full;
`endif

endmodule

// File: rtl/fsgnj_arb.sv
// Two-requester round-robin front end for one FSGNJ datapath with a one-entry
// output register. Optional NaN-box handling: define FSGNJ_NANBOX_EN.
module fsgnj_arb
  import fsgnj_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BUS_WIDTH-1:0] req0_in1,
  input  logic [BUS_WIDTH-1:0] req0_in2,
  input  logic [1:0]           req0_op,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req0_fmt,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [BUS_WIDTH-1:0] req1_in1,
  input  logic [BUS_WIDTH-1:0] req1_in2,
  input  logic [1:0]           req1_op,
  input  logic [TAG_W-1:0]     req1_tag,
  input  logic                 req1_fmt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_src
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on the payload, and at most one requester is ready.
  out_state_e           r_state;
  out_state_e           w_state_nxt;
  logic                 r_rr_ptr;
  logic [BUS_WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0]     r_out_tag;
  logic                 r_out_src;

  logic                 w_can_accept;
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_grant_any;
  logic [BUS_WIDTH-1:0] w_in1;
  logic [BUS_WIDTH-1:0] w_in2;
  logic [1:0]           w_op;
  logic                 w_fmt;
  logic [BUS_WIDTH-1:0] w_result;

  assign w_can_accept = (r_state == OUT_EMPTY) || out_ready;
  assign w_grant0 = !rst && w_can_accept && req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_grant1 = !rst && w_can_accept && req1_valid && (!req0_valid ||  r_rr_ptr);
  assign w_grant_any = w_grant0 || w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_in1 = w_grant1 ? req1_in1 : req0_in1;
  assign w_in2 = w_grant1 ? req1_in2 : req0_in2;
  assign w_op  = w_grant1 ? req1_op  : req0_op;
  assign w_fmt = w_grant1 ? req1_fmt : req0_fmt;

  fsgnj_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .i_in1    (w_in1),
    .i_in2    (w_in2),
    .i_op     (w_op),
    .i_fmt    (w_fmt),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= OUT_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // A grant while FULL means the register drains and reloads in the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_grant_any) w_state_nxt = OUT_FULL;
      OUT_FULL:  if (!w_grant_any && out_ready) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_out_data <= '0;
      r_out_tag  <= '0;
      r_out_src  <= 1'b0;
    end else if (w_grant_any) begin
      r_rr_ptr   <= ~w_grant1;
      r_out_data <= w_result;
      r_out_tag  <= w_grant1 ? req1_tag : req0_tag;
      r_out_src  <= w_grant1;
    end
  end

  assign out_valid = (r_state == OUT_FULL);
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_fsgnj_arb.sv
// Self-checking bench for fsgnj_arb: directed op/contention/backpressure/reset
// cases plus a random phase, all results checked through an expected queue.
module tb_fsgnj_arb;

  localparam int W  = 64;
  localparam int TW = 5;
  localparam int SBW = 1 + TW + W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          req0_fmt = 1'b0, req1_fmt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_src;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SBW-1:0] exp_q[$];
  logic           hold_prev = 1'b0;
  logic [SBW-1:0] prev_word = '0;

  fsgnj_arb #(.BUS_WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_op(req0_op), .req0_tag(req0_tag), .req0_fmt(req0_fmt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_op(req1_op), .req1_tag(req1_tag), .req1_fmt(req1_fmt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_src(out_src)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [SBW-1:0] got, input logic [SBW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic fmt);
    logic        s;
    logic [31:0] x, y;
    logic [W-1:0] r;
    s = (op == 2'b01) ? ~b[63] : (op == 2'b10) ? (a[63] ^ b[63]) : b[63];
    r = {s, a[62:0]};
    x = a[31:0];
    y = b[31:0];
`ifdef FSGNJ_NANBOX_EN
    if (fmt) begin
      if (a[63:32] != 32'hFFFFFFFF) x = 32'h7FC00000;
      if (b[63:32] != 32'hFFFFFFFF) y = 32'h7FC00000;
      s = (op == 2'b01) ? ~y[31] : (op == 2'b10) ? (x[31] ^ y[31]) : y[31];
      r = {32'hFFFFFFFF, s, x[30:0]};
    end
`else
    if (fmt && (x != x || y != y)) r = '0;
`endif
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      check("ready_onehot", {{(SBW-1){1'b0}}, req0_ready & req1_ready}, '0);
      if (hold_prev) check("hold_stable", {out_src, out_tag, out_data}, prev_word);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", '0, {{(SBW-1){1'b0}}, 1'b1});
        else check("sb_out", {out_src, out_tag, out_data}, exp_q.pop_front());
      end
      if (req0_valid && req0_ready)
        exp_q.push_back({1'b0, req0_tag, model(req0_in1, req0_in2, req0_op, req0_fmt)});
      if (req1_valid && req1_ready)
        exp_q.push_back({1'b1, req1_tag, model(req1_in1, req1_in2, req1_op, req1_fmt)});
      hold_prev = out_valid && !out_ready;
      prev_word = {out_src, out_tag, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [TW-1:0] tag, input logic fmt);
    int n;
    @(posedge clk); #1;
    if (k == 0) begin
      req0_in1 = a; req0_in2 = b; req0_op = op; req0_tag = tag; req0_fmt = fmt; req0_valid = 1'b1;
    end else begin
      req1_in1 = a; req1_in2 = b; req1_op = op; req1_tag = tag; req1_fmt = fmt; req1_valid = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((k == 0) ? req0_ready : req1_ready) && n < 50);
    if (n >= 50) check("ready_timeout", '0, {{(SBW-1){1'b0}}, 1'b1});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Issue on req0 with out_ready high and check the result one cycle after accept.
  task automatic op_case(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic [TW-1:0] tag, input logic fmt,
                         input logic [W-1:0] exp);
    issue(0, a, b, op, tag, fmt);
    @(negedge clk);
    check({name, "_valid"}, {{(SBW-1){1'b0}}, out_valid}, {{(SBW-1){1'b0}}, 1'b1});
    check({name, "_data"}, {{(SBW-W){1'b0}}, out_data}, {{(SBW-W){1'b0}}, exp});
    check({name, "_tag"}, {{(SBW-TW){1'b0}}, out_tag}, {{(SBW-TW){1'b0}}, tag});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req0_valid = 1'b1;
    @(negedge clk);
    check("rst_valid", {{(SBW-1){1'b0}}, out_valid}, '0);
    check("rst_data",  {{(SBW-W){1'b0}}, out_data}, '0);
    check("rst_tag",   {{(SBW-TW){1'b0}}, out_tag}, '0);
    check("rst_src",   {{(SBW-1){1'b0}}, out_src}, '0);
    check("rst_ready", {{(SBW-1){1'b0}}, req0_ready}, '0);
    req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Op results
    out_ready = 1'b1;
    op_case("op_j",   64'h3FF0000000000000, 64'h8000000000000000, 2'b00, 5'd3, 1'b0, 64'hBFF0000000000000);
    op_case("op_jn",  64'h3FF0000000000000, 64'h8000000000000000, 2'b01, 5'd4, 1'b0, 64'h3FF0000000000000);
    op_case("op_jx",  64'hBFF0000000000000, 64'h8000000000000000, 2'b10, 5'd5, 1'b0, 64'h3FF0000000000000);
    op_case("op_rsv", 64'h3FF0000000000000, 64'h8000000000000000, 2'b11, 5'd6, 1'b0, 64'hBFF0000000000000);
    op_case("nan_jn", 64'h7FF8000000000001, 64'h0000000000000000, 2'b01, 5'd7, 1'b0, 64'hFFF8000000000001);
`ifdef FSGNJ_NANBOX_EN
    op_case("box_bad", 64'h000000003F800000, 64'hFFFFFFFF80000000, 2'b00, 5'd8, 1'b1, 64'hFFFFFFFFFFC00000);
    op_case("box_ok",  64'hFFFFFFFF3F800000, 64'hFFFFFFFF80000000, 2'b00, 5'd9, 1'b1, 64'hFFFFFFFFBF800000);
`endif

    // Contention from a fresh rr_ptr
    do_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_in1 = {$urandom, $urandom}; req0_in2 = {$urandom, $urandom}; req0_op = 2'($urandom_range(0, 3));
      req1_in1 = {$urandom, $urandom}; req1_in2 = {$urandom, $urandom}; req1_op = 2'($urandom_range(0, 3));
      req0_tag = 5'(8 + i); req1_tag = 5'(16 + i);
      @(negedge clk);
      check("rr_grant0", {{(SBW-1){1'b0}}, req0_ready}, {{(SBW-1){1'b0}}, (i % 2 == 0)});
      check("rr_grant1", {{(SBW-1){1'b0}}, req1_ready}, {{(SBW-1){1'b0}}, (i % 2 == 1)});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: hold one result, both requesters blocked
    @(posedge clk); #1 out_ready = 1'b0;
    issue(0, 64'hC000000000000000, 64'h0, 2'b00, 5'd21, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_in1 = 64'h0123456789ABCDEF; req1_in2 = 64'h8000000000000000; req1_op = 2'b00; req1_tag = 5'd22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready0", {{(SBW-1){1'b0}}, req0_ready}, '0);
      check("bp_ready1", {{(SBW-1){1'b0}}, req1_ready}, '0);
      check("bp_data", {{(SBW-W){1'b0}}, out_data}, {{(SBW-W){1'b0}}, 64'h4000000000000000});
      check("bp_tag", {{(SBW-TW){1'b0}}, out_tag}, {{(SBW-TW){1'b0}}, 5'd21});
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release1", {{(SBW-1){1'b0}}, req1_ready}, {{(SBW-1){1'b0}}, 1'b1});
    check("bp_release0", {{(SBW-1){1'b0}}, req0_ready}, '0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("bp_next_src", {{(SBW-1){1'b0}}, out_src}, {{(SBW-1){1'b0}}, 1'b1});
    check("bp_next_data", {{(SBW-W){1'b0}}, out_data}, {{(SBW-W){1'b0}}, 64'h8123456789ABCDEF});

    // Reset mid-operation
    @(posedge clk); #1 out_ready = 1'b0;
    issue(1, 64'h1111, 64'h0, 2'b01, 5'd30, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_async_valid", {{(SBW-1){1'b0}}, out_valid}, '0);
    check("rst_async_ready", {{(SBW-1){1'b0}}, req1_ready | req0_ready}, '0);
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_in1 = 64'h5; req0_in2 = 64'h0; req0_op = 2'b00; req0_tag = 5'd1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rr_req0", {{(SBW-1){1'b0}}, req0_ready}, {{(SBW-1){1'b0}}, 1'b1});
    check("rst_rr_req1", {{(SBW-1){1'b0}}, req1_ready}, '0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_in1 = {$urandom, $urandom}; req0_in2 = {$urandom, $urandom};
      req1_in1 = {$urandom, $urandom}; req1_in2 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req0_in1[63:32] = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) req1_in2[63:32] = 32'hFFFFFFFF;
      req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
      req0_tag = 5'($urandom_range(0, 31)); req1_tag = 5'($urandom_range(0, 31));
      req0_fmt = 1'($urandom_range(0, 1)); req1_fmt = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain and report
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("sb_drain", SBW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
